mmio_gpio_bank: RTL and testbench

- Memory-mapped multi-channel GPIO bank for the single-cycle ARM system bus; replaces the fixed 8-bit in/out port pair at 0x800.
- Provides NCH channels of WIDTH bits, each with output data, per-bit direction, input synchronizer, rising-edge capture and a maskable interrupt.
- Sits beside dmem. The top selects rd over dmem data when hit=1. Reads are combinational and writes commit on posedge clk, matching the single-cycle bus timing.

---
 rtl/mmio_gpio_pkg.sv | 32 +++
 rtl/gpio_channel.sv | 97 +++++++++
 rtl/mmio_gpio_bank.sv | 101 ++++++++++
 tb/tb_mmio_gpio_bank.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mmio_gpio_pkg.sv
// Shared definitions for the memory-mapped GPIO bank: register offsets
// within a channel's 16-byte slot and the register-select decode.
package mmio_gpio_pkg;

    localparam logic [3:0] OFF_DATA = 4'h0;
    localparam logic [3:0] OFF_DIR  = 4'h4;
    localparam logic [3:0] OFF_IEN  = 4'h8;
    localparam logic [3:0] OFF_STAT = 4'hC;

    typedef enum logic [2:0] {
        SEL_DATA,
        SEL_DIR,
        SEL_IEN,
        SEL_STAT,
        SEL_NONE
    } reg_sel_e;

    // Map the low address nibble onto a register; anything that is not one
    // of the four word offsets (including misaligned bytes) selects nothing.
    function automatic reg_sel_e decode_offset(input logic [3:0] off);
        reg_sel_e sel;
        case (off)
            OFF_DATA: sel = SEL_DATA;
            OFF_DIR:  sel = SEL_DIR;
            OFF_IEN:  sel = SEL_IEN;
            OFF_STAT: sel = SEL_STAT;
            default:  sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/gpio_channel.sv
// One GPIO channel: output data, direction, interrupt enable and sticky
// rising-edge status registers, plus the input synchronizer and edge detect.
module gpio_channel
    import mmio_gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             armed_i,
    input  logic             wr_en_i,
    input  reg_sel_e         sel_i,
    input  logic [WIDTH-1:0] wd_i,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] pin_o,
    output logic [WIDTH-1:0] oe_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic             irq_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_w;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] out_q,  out_d;
    logic [WIDTH-1:0] dir_q,  dir_d;
    logic [WIDTH-1:0] ien_q,  ien_d;
    logic [WIDTH-1:0] stat_q, stat_d;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] clr_w;

    assign sync_w = sync_q[SYNC_STAGES-1];

    // Input synchronizer shift chain and previous-sample register for edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q <= sync_w;
        end
    end

    // Only input-direction pins capture edges, and only once the bank is armed
    // so that pins already high across reset release do not register as rises.
    assign rise_w = sync_w & ~prev_q & ~dir_q & {WIDTH{armed_i}};
    assign clr_w  = (wr_en_i && (sel_i == SEL_STAT)) ? wd_i : '0;

    // Next-state for the software-visible registers; a rise beats a clear.
    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        ien_d  = ien_q;
        if (wr_en_i) begin
            case (sel_i)
                SEL_DATA: out_d = wd_i;
                SEL_DIR:  dir_d = wd_i;
                SEL_IEN:  ien_d = wd_i;
                default:  ;
            endcase
        end
        stat_d = (stat_q & ~clr_w) | rise_w;
    end

    // Register state update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q  <= '0;
            dir_q  <= '0;
            ien_q  <= '0;
            stat_q <= '0;
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            ien_q  <= ien_d;
            stat_q <= stat_d;
        end
    end

    // Combinational read-back of the selected register.
    always_comb begin
        rdata_o = '0;
        case (sel_i)
            SEL_DATA: rdata_o = (dir_q & out_q) | (~dir_q & sync_w);
            SEL_DIR:  rdata_o = dir_q;
            SEL_IEN:  rdata_o = ien_q;
            SEL_STAT: rdata_o = stat_q;
            default:  rdata_o = '0;
        endcase
    end

    assign pin_o = out_q;
    assign oe_o  = dir_q;
    assign irq_o = |(stat_q & ien_q);

endmodule

// File: rtl/mmio_gpio_bank.sv
// Memory-mapped GPIO bank on the single-cycle system bus: decodes a window of
// 16-byte channel slots, muxes combinational read data and arms edge capture
// a few cycles after reset so synchronizer fill-up is not seen as an edge.
module mmio_gpio_bank
    import mmio_gpio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h800,
    parameter int          NCH         = 4,
    parameter int          WIDTH       = 8,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            adr,
    input  logic [31:0]            wd,
    input  logic                   we,
    output logic [31:0]            rd,
    output logic                   hit,
    input  logic [NCH*WIDTH-1:0]   pin_in,
    output logic [NCH*WIDTH-1:0]   pin_out,
    output logic [NCH*WIDTH-1:0]   pin_oe,
    output logic                   irq
);

    localparam int          CW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(16 * NCH);
    localparam int          ARM_N    = SYNC_STAGES + 1;
    localparam int          AW       = $clog2(ARM_N + 1);

    logic [31:0]      offset_w;
    logic [CW-1:0]    chan_idx_w;
    reg_sel_e         sel_w;
    logic [AW-1:0]    arm_q, arm_d;
    logic             armed_w;
    logic [WIDTH-1:0] rdata_w [NCH];
    logic [NCH-1:0]   irq_w;
    logic [WIDTH-1:0] rd_word_w;
    logic             unused_bits;

    // Window decode; the compare is done one bit wider so a window touching
    // the top of the address space cannot wrap.
    assign hit        = ({1'b0, adr} >= {1'b0, BASE_ADDR}) && ({1'b0, adr} < END_ADDR);
    assign offset_w   = adr - BASE_ADDR;
    assign chan_idx_w = offset_w[4 +: CW];
    assign sel_w      = decode_offset(adr[3:0]);

    // Upper write-data bits and the unused offset bits are intentionally ignored.
    assign unused_bits = &{1'b0, wd, offset_w};

    // Arm counter: saturates once the synchronizer and prev flops hold real samples.
    always_comb begin
        arm_d = armed_w ? arm_q : arm_q + AW'(1);
    end

    assign armed_w = (arm_q == AW'(ARM_N));

    // Arm counter register, restarted by every reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arm_q <= '0;
        end else begin
            arm_q <= arm_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            gpio_channel #(
                .WIDTH       (WIDTH),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_ch (
                .clk     (clk),
                .reset   (reset),
                .armed_i (armed_w),
                .wr_en_i (we && hit && (chan_idx_w == CW'(gi))),
                .sel_i   (sel_w),
                .wd_i    (wd[WIDTH-1:0]),
                .pin_i   (pin_in[gi*WIDTH +: WIDTH]),
                .pin_o   (pin_out[gi*WIDTH +: WIDTH]),
                .oe_o    (pin_oe[gi*WIDTH +: WIDTH]),
                .rdata_o (rdata_w[gi]),
                .irq_o   (irq_w[gi])
            );
        end
    endgenerate

    // Read mux: pick the addressed channel's word, zero outside the window.
    always_comb begin
        rd_word_w = '0;
        for (int c = 0; c < NCH; c++) begin
            if (chan_idx_w == CW'(c)) begin
                rd_word_w = rdata_w[c];
            end
        end
        rd = hit ? 32'(rd_word_w) : 32'h0;
    end

    assign irq = |irq_w;

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// Directed self-checking bench for mmio_gpio_bank with default parameters.
module tb_mmio_gpio_bank;

    logic        clk;
    logic        reset;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rd;
    logic        hit;
    logic [31:0] pin_in;
    logic [31:0] pin_out;
    logic [31:0] pin_oe;
    logic        irq;

    int n_cmp;
    int n_bad;

    mmio_gpio_bank dut (
        .clk     (clk),
        .reset   (reset),
        .adr     (adr),
        .wd      (wd),
        .we      (we),
        .rd      (rd),
        .hit     (hit),
        .pin_in  (pin_in),
        .pin_out (pin_out),
        .pin_oe  (pin_oe),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        adr = a;
        wd  = d;
        we  = 1'b1;
        tick();
        we  = 1'b0;
        $display("write adr=%h wd=%h", a, d);
    endtask

    task automatic bus_read(input logic [31:0] a);
        adr = a;
        #1;
        $display("read  adr=%h rd=%h hit=%0b irq=%0b", a, rd, hit, irq);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        bus_read(32'h800);
        n_cmp++; if (pin_out !== 32'h0) begin n_bad++; $display("FAIL reset_pin_out: got %h expected %h", pin_out, 32'h0); end
        n_cmp++; if (pin_oe !== 32'h0) begin n_bad++; $display("FAIL reset_pin_oe: got %h expected %h", pin_oe, 32'h0); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b expected 0", irq); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h expected %h", rd, 32'h0); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_output();
        bus_write(32'h804, 32'hFF);
        bus_write(32'h800, 32'hA5);
        bus_read(32'h800);
        n_cmp++; if (pin_out !== 32'h0000_00A5) begin n_bad++; $display("FAIL out_pin_out: got %h expected %h", pin_out, 32'hA5); end
        n_cmp++; if (pin_oe !== 32'h0000_00FF) begin n_bad++; $display("FAIL out_pin_oe: got %h expected %h", pin_oe, 32'hFF); end
        n_cmp++; if (rd !== 32'h0000_00A5) begin n_bad++; $display("FAIL out_read: got %h expected %h", rd, 32'hA5); end
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL out_hit: got %b expected 1", hit); end
    endtask

    task automatic test_sync();
        pin_in[15:8] = 8'h3C;
        adr = 32'h810;
        tick();
        bus_read(32'h810);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL sync_stale: got %h expected %h", rd, 32'h0); end
        tick();
        bus_read(32'h810);
        n_cmp++; if (rd !== 32'h3C) begin n_bad++; $display("FAIL sync_visible: got %h expected %h", rd, 32'h3C); end
    endtask

    task automatic test_irq();
        tick();
        bus_read(32'h81C);
        n_cmp++; if (rd !== 32'h3C) begin n_bad++; $display("FAIL irq_stat_prior: got %h expected %h", rd, 32'h3C); end
        bus_write(32'h81C, 32'hFF);
        bus_read(32'h81C);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL irq_clear_all: got %h expected %h", rd, 32'h0); end
        bus_write(32'h818, 32'h01);
        pin_in[8] = 1'b1;
        tick();
        tick();
        bus_read(32'h81C);
        n_cmp++; if (rd !== 32'h0 || irq !== 1'b0) begin n_bad++; $display("FAIL irq_early: got stat=%h irq=%b expected 0/0", rd, irq); end
        tick();
        bus_read(32'h81C);
        n_cmp++; if (rd !== 32'h01) begin n_bad++; $display("FAIL irq_stat_set: got %h expected %h", rd, 32'h01); end
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_assert: got %b expected 1", irq); end
        bus_write(32'h81C, 32'h00);
        bus_read(32'h81C);
        n_cmp++; if (rd !== 32'h01 || irq !== 1'b1) begin n_bad++; $display("FAIL irq_w0_noop: got stat=%h irq=%b expected 01/1", rd, irq); end
        bus_write(32'h81C, 32'h01);
        bus_read(32'h81C);
        n_cmp++; if (rd !== 32'h0 || irq !== 1'b0) begin n_bad++; $display("FAIL irq_w1c: got stat=%h irq=%b expected 0/0", rd, irq); end
    endtask

    task automatic test_set_wins();
        pin_in[8] = 1'b0;
        repeat (3) tick();
        pin_in[8] = 1'b1;
        repeat (3) tick();
        bus_read(32'h81C);
        n_cmp++; if (rd !== 32'h01) begin n_bad++; $display("FAIL setwin_pre: got %h expected %h", rd, 32'h01); end
        pin_in[8] = 1'b0;
        repeat (3) tick();
        pin_in[8] = 1'b1;
        tick();
        tick();
        bus_write(32'h81C, 32'h01);
        bus_read(32'h81C);
        n_cmp++; if (rd !== 32'h01) begin n_bad++; $display("FAIL setwin_collide: got %h expected %h", rd, 32'h01); end
        bus_write(32'h81C, 32'h01);
        bus_read(32'h81C);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL setwin_clear: got %h expected %h", rd, 32'h0); end
        pin_in[9] = 1'b1;
        repeat (3) tick();
        bus_read(32'h81C);
        n_cmp++; if (rd !== 32'h02) begin n_bad++; $display("FAIL masked_stat: got %h expected %h", rd, 32'h02); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL masked_irq: got %b expected 0", irq); end
    endtask

    task automatic test_arm();
        logic [31:0] stat_adr;
        pin_in = 32'hFFFF_FFFF;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        bus_write(32'h808, 32'hFF);
        bus_write(32'h818, 32'hFF);
        bus_write(32'h828, 32'hFF);
        bus_write(32'h838, 32'hFF);
        repeat (4) tick();
        for (int c = 0; c < 4; c++) begin
            stat_adr = 32'h80C + 32'(c * 16);
            bus_read(stat_adr);
            n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL arm_stat_ch%0d: got %h expected %h", c, rd, 32'h0); end
        end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL arm_irq: got %b expected 0", irq); end
        bus_read(32'h800);
        n_cmp++; if (rd !== 32'hFF) begin n_bad++; $display("FAIL arm_data: got %h expected %h", rd, 32'hFF); end
        pin_in[0] = 1'b0;
        repeat (3) tick();
        pin_in[0] = 1'b1;
        repeat (3) tick();
        bus_read(32'h80C);
        n_cmp++; if (rd !== 32'h01) begin n_bad++; $display("FAIL arm_toggle_stat: got %h expected %h", rd, 32'h01); end
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL arm_toggle_irq: got %b expected 1", irq); end
    endtask

    task automatic test_decode();
        bus_read(32'h840);
        n_cmp++; if (hit !== 1'b0 || rd !== 32'h0) begin n_bad++; $display("FAIL dec_above: got hit=%b rd=%h expected 0/0", hit, rd); end
        bus_read(32'h7FC);
        n_cmp++; if (hit !== 1'b0 || rd !== 32'h0) begin n_bad++; $display("FAIL dec_below: got hit=%b rd=%h expected 0/0", hit, rd); end
        bus_read(32'h83C);
        n_cmp++; if (hit !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL dec_last: got hit=%b rd=%h expected 1/0", hit, rd); end
        bus_read(32'h802);
        n_cmp++; if (hit !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL dec_misaligned: got hit=%b rd=%h expected 1/0", hit, rd); end
        bus_write(32'h840, 32'h5A);
        bus_write(32'h844, 32'hFF);
        bus_write(32'h802, 32'h77);
        bus_write(32'h806, 32'hFF);
        n_cmp++; if (pin_out !== 32'h0) begin n_bad++; $display("FAIL dec_wr_out: got %h expected %h", pin_out, 32'h0); end
        n_cmp++; if (pin_oe !== 32'h0) begin n_bad++; $display("FAIL dec_wr_oe: got %h expected %h", pin_oe, 32'h0); end
        bus_write(32'h804, 32'hFF);
        bus_write(32'h800, 32'h3C);
        n_cmp++; if (pin_out !== 32'h3C || irq !== 1'b1) begin n_bad++; $display("FAIL midrst_pre: got out=%h irq=%b expected 3c/1", pin_out, irq); end
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        $display("async reset: pin_out=%h pin_oe=%h irq=%b", pin_out, pin_oe, irq);
        n_cmp++; if (pin_out !== 32'h0) begin n_bad++; $display("FAIL midrst_out: got %h expected %h", pin_out, 32'h0); end
        n_cmp++; if (pin_oe !== 32'h0) begin n_bad++; $display("FAIL midrst_oe: got %h expected %h", pin_oe, 32'h0); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL midrst_irq: got %b expected 0", irq); end
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        reset  = 1'b1;
        adr    = 32'h0;
        wd     = 32'h0;
        we     = 1'b0;
        pin_in = 32'h0;
        test_reset();
        test_output();
        test_sync();
        test_irq();
        test_set_wins();
        test_arm();
        test_decode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
